jp_bridge: RTL and testbench



---
 rtl/jp_bridge_if.sv | 58 +++++
 rtl/jp_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_jp_bridge.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jp_bridge_if.sv
// ---------------------------------------------------------------------------
// jp_bridge_if
//
// Groups the pad-pin and emulated-joypad signals of jp_bridge. clk_in and
// rst_in stay plain module ports.
//
// Signals:
//   pad_data_in       raw serial data from the pad pin (active-low buttons,
//                     pulled high when no pad is connected)
//   pad_latch_out     pad latch, active-high
//   pad_clk_out       pad shift clock, active-high pulse
//   emu_latch_in      rp2a03 jp_latch
//   emu_clk_in        rp2a03 jpN_clk
//   emu_data_out      emulated serial data toward rp2a03 (0 = pressed)
//   buttons_out[7:0]  committed buttons, 1 = pressed
//                     (A, B, Select, Start, Up, Down, Left, Right)
//   pad_present_out   last committed poll detected a pad
//   frame_strobe_out  one-cycle pulse when a poll commits
//
// Modports:
//   master  the bridge itself
//   slave   its surroundings (pad pins, rp2a03, status consumers)
// ---------------------------------------------------------------------------
interface jp_bridge_if;
    logic       pad_data_in;
    logic       pad_latch_out;
    logic       pad_clk_out;
    logic       emu_latch_in;
    logic       emu_clk_in;
    logic       emu_data_out;
    logic [7:0] buttons_out;
    logic       pad_present_out;
    logic       frame_strobe_out;

    modport master (
        input  pad_data_in,
        input  emu_latch_in,
        input  emu_clk_in,
        output pad_latch_out,
        output pad_clk_out,
        output emu_data_out,
        output buttons_out,
        output pad_present_out,
        output frame_strobe_out
    );

    modport slave (
        output pad_data_in,
        output emu_latch_in,
        output emu_clk_in,
        input  pad_latch_out,
        input  pad_clk_out,
        input  emu_data_out,
        input  buttons_out,
        input  pad_present_out,
        input  frame_strobe_out
    );
endinterface

// File: rtl/jp_bridge.sv
// ---------------------------------------------------------------------------
// jp_bridge
//
// Bridge between a physical NES controller port and the rp2a03 joypad
// inputs. A poller reads the pad at a fixed rate and keeps a clean 8-bit
// button image plus a pad-present flag; an emulated 4021 shift register
// serves rp2a03 reads from that committed image, so CPU reads never touch
// the raw pin.
//
// Parameters:
//   HALF_BIT  clk_in cycles per pad clock half-period
//   POLL_DIV  clk_in cycles between poll starts (>= 20*HALF_BIT)
//
// Ports:
//   clk_in    system clock (clk_25 domain)
//   rst_in    synchronous, active-high reset
//   bus       jp_bridge_if.master (pad pins, emulated joypad, status)
//
// Build option:
//   JP_BRIDGE_DEBOUNCE_EN  when defined, buttons_out only takes a new image
//                          once two consecutive polls sampled the same
//                          8 bits. Undefined: every present poll updates.
// ---------------------------------------------------------------------------
module jp_bridge #(
    parameter int HALF_BIT = 150,
    parameter int POLL_DIV = 416667
) (
    input  logic        clk_in,
    input  logic        rst_in,
    jp_bridge_if.master bus
);

    localparam int PH_W   = (2 * HALF_BIT > 1) ? $clog2(2 * HALF_BIT) : 1;
    localparam int POLL_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

    localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(2 * HALF_BIT - 1);
    localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_BIT - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WAIT0,
        CLK_HI,
        CLK_LO,
        COMMIT
    } state_t;

    // -----------------------------------------------------------------------
    // Pad data synchronizer. Resets to 1 so an idle pin reads as "released".
    // -----------------------------------------------------------------------
    logic pad_meta;
    logic pad_sync;

    // NOTE: every clocked register uses non-blocking (<=) assignments so all
    // flops update together from pre-edge values; blocking here would let
    // pad_sync see the new pad_meta in the same edge and collapse the stage.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pad_meta <= 1'b1;
            pad_sync <= 1'b1;
        end else begin
            pad_meta <= bus.pad_data_in;
            pad_sync <= pad_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Free-running poll divider; tick at count 0, so the first tick lands on
    // the first cycle after reset release.
    // -----------------------------------------------------------------------
    logic [POLL_W-1:0] poll_cnt;
    logic              poll_tick;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + POLL_W'(1);
        end
    end

    assign poll_tick = (poll_cnt == '0);

    // -----------------------------------------------------------------------
    // Poll FSM with registered pad outputs and committed status.
    // -----------------------------------------------------------------------
    state_t          state;
    logic [PH_W-1:0] ph_cnt;     // cycles spent in the current phase
    logic [3:0]      bit_cnt;    // index of the next bit to sample
    logic [8:0]      samples;    // shifted in LSB-first; bit0 ends at [0]
    logic            pad_latch;
    logic            pad_clk;
    logic [7:0]      buttons;
    logic            present;
    logic            strobe;
`ifdef JP_BRIDGE_DEBOUNCE_EN
    logic [7:0]      prev_sample; // raw pin image from the previous poll
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            ph_cnt      <= '0;
            bit_cnt     <= '0;
            samples     <= '1;
            pad_latch   <= 1'b0;
            pad_clk     <= 1'b0;
            buttons     <= '0;
            present     <= 1'b0;
            strobe      <= 1'b0;
`ifdef JP_BRIDGE_DEBOUNCE_EN
            // All-released image, so a pad held down at power-up still
            // needs two matching polls before it shows.
            prev_sample <= '1;
`endif
        end else begin
            strobe <= 1'b0;

            case (state)
                IDLE: begin
                    // Ticks seen in any other state are dropped on purpose.
                    if (poll_tick) begin
                        state     <= LATCH;
                        ph_cnt    <= '0;
                        pad_latch <= 1'b1;
                    end
                end

                LATCH: begin
                    if (ph_cnt == LATCH_LAST) begin
                        state     <= WAIT0;
                        ph_cnt    <= '0;
                        pad_latch <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end

                WAIT0: begin
                    // Bit0 is already on the pin once the pad has latched.
                    if (ph_cnt == HALF_LAST) begin
                        samples <= {pad_sync, samples[8:1]};
                        bit_cnt <= 4'd1;
                        state   <= CLK_HI;
                        ph_cnt  <= '0;
                        pad_clk <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end

                CLK_HI: begin
                    if (ph_cnt == HALF_LAST) begin
                        state   <= CLK_LO;
                        ph_cnt  <= '0;
                        pad_clk <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end

                CLK_LO: begin
                    // Sample at the end of the low phase, well after the pad
                    // has shifted and the synchronizer has settled.
                    if (ph_cnt == HALF_LAST) begin
                        samples <= {pad_sync, samples[8:1]};
                        ph_cnt  <= '0;
                        if (bit_cnt == 4'd8) begin
                            state <= COMMIT;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            state   <= CLK_HI;
                            pad_clk <= 1'b1;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end

                COMMIT: begin
                    // A real pad shifts in ground after its 8 buttons, so
                    // bit8 low means a pad is present; the pull-up gives 1.
                    strobe <= 1'b1;
                    state  <= IDLE;
                    if (!samples[8]) begin
                        present <= 1'b1;
`ifdef JP_BRIDGE_DEBOUNCE_EN
                        if (samples[7:0] == prev_sample) begin
                            buttons <= ~samples[7:0];
                        end
`else
                        buttons <= ~samples[7:0];
`endif
                    end else begin
                        present <= 1'b0;
                        buttons <= '0;
                    end
`ifdef JP_BRIDGE_DEBOUNCE_EN
                    prev_sample <= samples[7:0];
`endif
                end

                default: begin
                    state     <= IDLE;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Emulated 4021 toward rp2a03. Loads only from committed values, so a
    // commit landing mid-read does not disturb the bits already in flight.
    // -----------------------------------------------------------------------
    logic [7:0] emu_sh;
    logic       emu_fill;    // shifted in after the 8 buttons
    logic       emu_clk_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            emu_sh    <= 8'hFF;
            emu_fill  <= 1'b1;
            emu_clk_d <= 1'b0;
        end else begin
            emu_clk_d <= bus.emu_clk_in;
            // Latch has priority: a clock edge coinciding with latch high is
            // swallowed, matching a parallel-load 4021.
            if (bus.emu_latch_in) begin
                emu_sh   <= ~buttons;
                emu_fill <= ~present;
            end else if (bus.emu_clk_in && !emu_clk_d) begin
                emu_sh <= {emu_fill, emu_sh[7:1]};
            end
        end
    end

    assign bus.pad_latch_out    = pad_latch;
    assign bus.pad_clk_out      = pad_clk;
    assign bus.emu_data_out     = emu_sh[0];
    assign bus.buttons_out      = buttons;
    assign bus.pad_present_out  = present;
    assign bus.frame_strobe_out = strobe;

endmodule

// File: tb/tb_jp_bridge.sv
// ---------------------------------------------------------------------------
// tb_jp_bridge
//
// Self-checking bench for jp_bridge with HALF_BIT=4, POLL_DIV=200. A
// behavioural 4021 pad model drives pad_data_in; a reference model holds the
// committed buttons/presence derived straight from the pin pattern of each
// poll, and predicts the emulated serial stream from them.
// ---------------------------------------------------------------------------
module tb_jp_bridge;

    localparam int HALF_BIT = 4;
    localparam int POLL_DIV = 200;
`ifdef JP_BRIDGE_DEBOUNCE_EN
    localparam int POLLS_PER_VEC = 2;
`else
    localparam int POLLS_PER_VEC = 1;
`endif

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    jp_bridge_if bus ();

    jp_bridge #(
        .HALF_BIT (HALF_BIT),
        .POLL_DIV (POLL_DIV)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    // -----------------------------------------------------------------------
    // Pad model: 4021 loaded while latch is high, advancing one bit per rising
    // pad clock; after bit8 it keeps presenting bit8 (ground for a real pad).
    // -----------------------------------------------------------------------
    logic [8:0] pad_pins  = 9'h1FF;
    int         pad_idx   = 0;
    logic       pad_clk_d = 1'b0;

    always @(posedge clk_in) begin
        pad_clk_d <= bus.pad_clk_out;
        if (bus.pad_latch_out === 1'b1) begin
            pad_idx <= 0;
        end else if (bus.pad_clk_out === 1'b1 && pad_clk_d === 1'b0 && pad_idx < 8) begin
            pad_idx <= pad_idx + 1;
        end
    end

    assign bus.pad_data_in = pad_pins[pad_idx];

    // -----------------------------------------------------------------------
    // Reference model of the committed state
    // -----------------------------------------------------------------------
    logic [7:0] m_buttons;
    logic       m_present;
    logic [7:0] m_prev;

    task automatic model_reset();
        m_buttons = 8'h00;
        m_present = 1'b0;
        m_prev    = 8'hFF;
    endtask

    task automatic model_commit(input logic [8:0] pins);
        if (pins[8] == 1'b0) begin
            m_present = 1'b1;
`ifdef JP_BRIDGE_DEBOUNCE_EN
            if (pins[7:0] == m_prev) m_buttons = ~pins[7:0];
`else
            m_buttons = ~pins[7:0];
`endif
        end else begin
            m_present = 1'b0;
            m_buttons = 8'h00;
        end
        m_prev = pins[7:0];
    endtask

    // Serial bit k seen by the CPU: 8 buttons (0 = pressed), then the fill.
    function automatic logic emu_expect(input logic [7:0] b, input logic p, input int k);
        if (k < 8) return ~b[k];
        return ~p;
    endfunction

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    // Waits for frame_strobe_out, counting pad clock rises and cycles; then
    // checks the strobe drops after one cycle.
    task automatic wait_frame(input string tag, output int pulses, output int cycles);
        logic prev_clk;
        bit   seen;
        seen     = 1'b0;
        pulses   = 0;
        cycles   = 0;
        prev_clk = bus.pad_clk_out;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk_in);
            cycles++;
            if (bus.pad_clk_out === 1'b1 && prev_clk !== 1'b1) pulses++;
            prev_clk = bus.pad_clk_out;
            if (bus.frame_strobe_out === 1'b1) seen = 1'b1;
        end
        check({tag, "_strobe_seen"}, 32'(seen), 32'd1);
        @(negedge clk_in);
        check({tag, "_strobe_one_cycle"}, 32'(bus.frame_strobe_out), 32'd0);
    endtask

    task automatic poll(input string tag, input logic [8:0] pins);
        int pulses;
        int cycles;
        pad_pins = pins;
        wait_frame(tag, pulses, cycles);
        model_commit(pins);
    endtask

    // Latch pulse, then 10 rising emu clock edges; checks 11 serial values.
    task automatic emu_readback(input string tag, input logic [7:0] b, input logic p);
        @(negedge clk_in);
        bus.emu_latch_in = 1'b1;
        bus.emu_clk_in   = 1'b0;
        @(negedge clk_in);
        bus.emu_latch_in = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            check($sformatf("%s_emu_bit%0d", tag, k), 32'(bus.emu_data_out),
                  32'(emu_expect(b, p, k)));
            if (k < 10) begin
                bus.emu_clk_in = 1'b1;
                @(negedge clk_in);
                bus.emu_clk_in = 1'b0;
                @(negedge clk_in);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Directed vectors: pin pattern bits 0..8 and the committed result.
    // -----------------------------------------------------------------------
    typedef struct {
        logic [8:0] pins;
        logic [7:0] exp_buttons;
        logic       exp_present;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int   hi;
        int   pulses;
        int   cycles;
        bit   seen;
        logic [8:0] rp;

        tbl[0] = '{pins: 9'h0F6, exp_buttons: 8'h09, exp_present: 1'b1}; // A+Start
        tbl[1] = '{pins: 9'h1FF, exp_buttons: 8'h00, exp_present: 1'b0}; // no pad
        tbl[2] = '{pins: 9'h000, exp_buttons: 8'hFF, exp_present: 1'b1}; // all pressed
        tbl[3] = '{pins: 9'h0FF, exp_buttons: 8'h00, exp_present: 1'b1}; // pad, idle
        tbl[4] = '{pins: 9'h02F, exp_buttons: 8'hD0, exp_present: 1'b1}; // Up+Left+Right

        bus.emu_latch_in = 1'b0;
        bus.emu_clk_in   = 1'b0;
        model_reset();

        // ---- reset values ---------------------------------------------------
        pad_pins = 9'h0F6;
        repeat (3) @(negedge clk_in);
        check("rst_pad_latch", 32'(bus.pad_latch_out), 32'd0);
        check("rst_pad_clk", 32'(bus.pad_clk_out), 32'd0);
        check("rst_buttons", 32'(bus.buttons_out), 32'd0);
        check("rst_present", 32'(bus.pad_present_out), 32'd0);
        check("rst_strobe", 32'(bus.frame_strobe_out), 32'd0);
        check("rst_emu_data", 32'(bus.emu_data_out), 32'd1);

        // ---- first poll: latch timing, pulse count, duration -----------------
        rst_in = 1'b0;
        @(negedge clk_in);
        check("latch_rise_after_release", 32'(bus.pad_latch_out), 32'd1);
        hi = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_in);
            if (bus.pad_latch_out !== 1'b1) break;
            hi++;
        end
        check("latch_high_cycles", 32'(hi), 32'(2 * HALF_BIT));
        wait_frame("first", pulses, cycles);
        model_commit(9'h0F6);
        check("first_pad_clk_pulses", 32'(pulses), 32'd8);
        check("first_poll_duration", 32'(hi + cycles), 32'(19 * HALF_BIT + 1));
        check("first_buttons", 32'(bus.buttons_out), 32'(m_buttons));
        check("first_present", 32'(bus.pad_present_out), 32'(m_present));

        // ---- latch and clock rising together: latch wins --------------------
        @(negedge clk_in);
        bus.emu_latch_in = 1'b1;
        bus.emu_clk_in   = 1'b1;
        @(negedge clk_in);
        bus.emu_latch_in = 1'b0;
        @(negedge clk_in);
        check("latch_wins_bit0", 32'(bus.emu_data_out), 32'(emu_expect(m_buttons, m_present, 0)));
        bus.emu_clk_in = 1'b0;
        @(negedge clk_in);
        bus.emu_clk_in = 1'b1;
        @(negedge clk_in);
        check("latch_wins_next_bit1", 32'(bus.emu_data_out), 32'(emu_expect(m_buttons, m_present, 1)));
        bus.emu_clk_in = 1'b0;
        @(negedge clk_in);

        // ---- directed table ---------------------------------------------------
        for (int v = 0; v < 5; v++) begin
            for (int r = 0; r < POLLS_PER_VEC; r++) begin
                poll($sformatf("tbl%0d_p%0d", v, r), tbl[v].pins);
            end
            check($sformatf("tbl%0d_buttons", v), 32'(bus.buttons_out), 32'(tbl[v].exp_buttons));
            check($sformatf("tbl%0d_present", v), 32'(bus.pad_present_out), 32'(tbl[v].exp_present));
            emu_readback($sformatf("tbl%0d", v), tbl[v].exp_buttons, tbl[v].exp_present);
        end

        // ---- randomized polls against the model -----------------------------
        for (int i = 0; i < 16; i++) begin
            rp = 9'($urandom);
            rp[8] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) rp[7:0] = m_prev;
            poll($sformatf("rnd%0d", i), rp);
            check($sformatf("rnd%0d_buttons", i), 32'(bus.buttons_out), 32'(m_buttons));
            check($sformatf("rnd%0d_present", i), 32'(bus.pad_present_out), 32'(m_present));
            emu_readback($sformatf("rnd%0d", i), m_buttons, m_present);
        end

        // ---- reset in the middle of CLK_HI ----------------------------------
        pad_pins = 9'h0F6;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk_in);
            if (bus.pad_clk_out === 1'b1) seen = 1'b1;
        end
        check("midpoll_clk_hi_seen", 32'(seen), 32'd1);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("midpoll_rst_pad_clk", 32'(bus.pad_clk_out), 32'd0);
        check("midpoll_rst_buttons", 32'(bus.buttons_out), 32'd0);
        check("midpoll_rst_present", 32'(bus.pad_present_out), 32'd0);
        check("midpoll_rst_strobe", 32'(bus.frame_strobe_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        // The aborted poll must commit nothing; the fresh poll after release
        // is the only one that may update the outputs.
        poll("after_rst", 9'h0F6);
        check("after_rst_buttons", 32'(bus.buttons_out), 32'(m_buttons));
        check("after_rst_present", 32'(bus.pad_present_out), 32'(m_present));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
